// File: rtl/mma_cmd_pkg.sv
// Shared definitions for the MMA host command front end.
// Contents: host opcode encoding, front-end FSM states, the config
// register map (indices) and the CTRL register bit positions.
package mma_cmd_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_READ   = 2'b01,
    OP_START  = 2'b10,
    OP_STATUS = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RSP     = 3'd4
  } fe_state_e;

  // Register map; indices 0..11 are full-width, 12 is CTRL, 13..15 illegal.
  localparam int REG_LHS_BASE   = 32'd0;
  localparam int REG_RHS_BASE   = 32'd1;
  localparam int REG_DST_BASE   = 32'd2;
  localparam int REG_BIAS_BASE  = 32'd3;
  localparam int REG_Q_MULT     = 32'd4;
  localparam int REG_Q_SHIFT    = 32'd5;
  localparam int REG_K          = 32'd6;
  localparam int REG_N          = 32'd7;
  localparam int REG_M          = 32'd8;
  localparam int REG_LHS_STRIDE = 32'd9;
  localparam int REG_DST_STRIDE = 32'd10;
  localparam int REG_RHS_STRIDE = 32'd11;
  localparam int REG_CTRL       = 32'd12;
  localparam int NUM_CFG_REGS   = 32'd12;

  localparam int CTRL_PER_CHANNEL_BIT = 32'd0;
  localparam int CTRL_16BITS_IA_BIT   = 32'd1;

endpackage

// File: rtl/mma_cmd_frontend.sv
// Host-side command front end for the MMA controller.
// Owns the configuration register file, issues calc_start, terminates the
// controller write-back handshake and returns one response per host command.
// Ports:
//   clk, rst                      clock, async active-high reset
//   cmd_valid/ready/op/addr/wdata host command channel
//   rsp_valid/ready/data/err      host response channel
//   lhs_base .. rhs_row_stride_b  config register outputs
//   use_per_channel, cfg_16bits_ia CTRL bits 0 and 1
//   calc_start, sa_ready          controller start pulse / idle indication
//   wb_valid, wb_ready, err_code  controller completion handshake + status
module mma_cmd_frontend
  import mma_cmd_pkg::*;
#(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [REG_WIDTH-1:0]  cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [REG_WIDTH-1:0]  rsp_data,
  output logic                  rsp_err,
  output logic [REG_WIDTH-1:0]  lhs_base,
  output logic [REG_WIDTH-1:0]  rhs_base,
  output logic [REG_WIDTH-1:0]  dst_base,
  output logic [REG_WIDTH-1:0]  bias_base,
  output logic [REG_WIDTH-1:0]  q_mult_pt,
  output logic [REG_WIDTH-1:0]  q_shift_pt,
  output logic [REG_WIDTH-1:0]  k,
  output logic [REG_WIDTH-1:0]  n,
  output logic [REG_WIDTH-1:0]  m,
  output logic [REG_WIDTH-1:0]  lhs_row_stride_b,
  output logic [REG_WIDTH-1:0]  dst_row_stride_b,
  output logic [REG_WIDTH-1:0]  rhs_row_stride_b,
  output logic                  use_per_channel,
  output logic                  cfg_16bits_ia,
  output logic                  calc_start,
  input  logic                  sa_ready,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [1:0]            err_code
);

  fe_state_e             state;
  fe_state_e             next_state;
  logic                  accept;
  logic                  addr_ok;
  logic [REG_WIDTH-1:0]  rd_data;
  logic [REG_WIDTH-1:0]  cfg [NUM_CFG_REGS];
  logic [1:0]            ctrl;
  logic [1:0]            last_err;
  logic [REG_WIDTH-3:0]  run_cnt;

  // Handshake outputs are pure state decodes; cmd_ready is also held low in reset.
  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign wb_ready  = (state == ST_RUN);
  assign rsp_valid = (state == ST_RSP);

  assign lhs_base         = cfg[REG_LHS_BASE];
  assign rhs_base         = cfg[REG_RHS_BASE];
  assign dst_base         = cfg[REG_DST_BASE];
  assign bias_base        = cfg[REG_BIAS_BASE];
  assign q_mult_pt        = cfg[REG_Q_MULT];
  assign q_shift_pt       = cfg[REG_Q_SHIFT];
  assign k                = cfg[REG_K];
  assign n                = cfg[REG_N];
  assign m                = cfg[REG_M];
  assign lhs_row_stride_b = cfg[REG_LHS_STRIDE];
  assign dst_row_stride_b = cfg[REG_DST_STRIDE];
  assign rhs_row_stride_b = cfg[REG_RHS_STRIDE];
  assign use_per_channel  = ctrl[CTRL_PER_CHANNEL_BIT];
  assign cfg_16bits_ia    = ctrl[CTRL_16BITS_IA_BIT];

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state, command accept and start pulse.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    calc_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          next_state = (cmd_op_e'(cmd_op) == OP_START) ? ST_ISSUE : ST_RSP;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (sa_ready) begin
          calc_start = 1'b1;
          next_state = ST_RUN;
        end else begin
          next_state = ST_ISSUE;
        end
      end
      // wb_ready is high for the whole of RUN, so wb_valid alone completes it.
      ST_RUN: begin
        if (wb_valid) begin
          next_state = ST_CAPTURE;
        end else begin
          next_state = ST_RUN;
        end
      end
      ST_CAPTURE: begin
        next_state = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_RSP;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Register read mux and address legality for WRITE/READ.
  always_comb begin
    rd_data = '0;
    addr_ok = (int'(cmd_addr) <= REG_CTRL);
    for (int i = 0; i < NUM_CFG_REGS; i++) begin
      rd_data = (int'(cmd_addr) == i) ? cfg[i] : rd_data;
    end
    rd_data = (int'(cmd_addr) == REG_CTRL) ? {{(REG_WIDTH-2){1'b0}}, ctrl} : rd_data;
  end

  // Register file, response capture and run statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CFG_REGS; i++) begin
        cfg[i] <= '0;
      end
      ctrl     <= 2'b00;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      last_err <= 2'b00;
      run_cnt  <= '0;
    end else begin
      // Commands are only accepted in IDLE, so config never moves during a run.
      if (accept) begin
        case (cmd_op_e'(cmd_op))
          OP_WRITE: begin
            for (int i = 0; i < NUM_CFG_REGS; i++) begin
              if (int'(cmd_addr) == i) begin
                cfg[i] <= cmd_wdata;
              end else begin
                cfg[i] <= cfg[i];
              end
            end
            if (int'(cmd_addr) == REG_CTRL) begin
              ctrl <= cmd_wdata[1:0];
            end else begin
              ctrl <= ctrl;
            end
            rsp_data <= '0;
            rsp_err  <= !addr_ok;
          end
          OP_READ: begin
            rsp_data <= addr_ok ? rd_data : '0;
            rsp_err  <= !addr_ok;
          end
          OP_STATUS: begin
            rsp_data <= {run_cnt, last_err};
            rsp_err  <= 1'b0;
          end
          OP_START: begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
          end
          default: begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
          end
        endcase
      end
      // The calc_start cycle itself counts as cycle 1; every RUN cycle
      // (including the handshake cycle) adds one, saturating at all-ones.
      if (calc_start) begin
        run_cnt <= {{(REG_WIDTH-3){1'b0}}, 1'b1};
      end else if ((state == ST_RUN) && (run_cnt != '1)) begin
        run_cnt <= run_cnt + {{(REG_WIDTH-3){1'b0}}, 1'b1};
      end
      // err_code becomes valid one cycle after the handshake, hence CAPTURE.
      if (state == ST_CAPTURE) begin
        last_err <= err_code;
        rsp_data <= {{(REG_WIDTH-2){1'b0}}, err_code};
        rsp_err  <= 1'b0;
      end
    end
  end

endmodule
